// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control sequencer for the 16-bit datapath (fetch/decode/execute/mem/writeback)
module mc_control_fsm #(
  parameter int OP_W = 4,
  parameter int ST_W = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [OP_W-1:0] Opcode,
  input  logic            MemReady,
  output logic            PCWrite,
  output logic            PCWriteBeq,
  output logic            PCWriteBne,
  output logic            IRWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IorD,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemToReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic [ST_W-1:0] State
);
  typedef enum logic [ST_W-1:0] {
    RST_IDLE = ST_W'(0),  FETCH  = ST_W'(1),  DECODE = ST_W'(2),  EXEC_R = ST_W'(3),
    WB_R     = ST_W'(4),  EXEC_I = ST_W'(5),  WB_I   = ST_W'(6),  MEM_ADDR = ST_W'(7),
    MEM_RD   = ST_W'(8),  MEM_WB = ST_W'(9),  MEM_WR = ST_W'(10), BRANCH = ST_W'(11),
    JUMP     = ST_W'(12), HALT   = ST_W'(13)
  } state_t;
  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);
  state_t          state;
  logic [OP_W-1:0] op_q;
  // State sequencing; the opcode is captured leaving DECODE so later IR changes cannot disturb the instruction
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= RST_IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        RST_IDLE: state <= FETCH;
        FETCH:    state <= MemReady ? DECODE : FETCH;
        DECODE: begin
          op_q <= Opcode;
          case (Opcode)
            OP_R:          state <= EXEC_R;
            OP_ADDI:       state <= EXEC_I;
            OP_LW, OP_SW:  state <= MEM_ADDR;
            OP_BEQ, OP_BNE: state <= BRANCH;
            OP_J:          state <= JUMP;
            OP_HALT:       state <= HALT;
            default:       state <= FETCH;
          endcase
        end
        EXEC_R:   state <= WB_R;
        WB_R:     state <= FETCH;
        EXEC_I:   state <= WB_I;
        WB_I:     state <= FETCH;
        MEM_ADDR: state <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   state <= MemReady ? MEM_WB : MEM_RD;
        MEM_WB:   state <= FETCH;
        MEM_WR:   state <= MemReady ? FETCH : MEM_WR;
        BRANCH:   state <= FETCH;
        JUMP:     state <= FETCH;
        HALT:     state <= HALT;
        default:  state <= RST_IDLE;
      endcase
    end
  end
  // Control decode from the current state; MemReady only gates the FETCH-cycle IR and PC loads
  always_comb begin
    PCWrite    = (state == FETCH && MemReady) || state == JUMP;
    PCWriteBeq = state == BRANCH && op_q == OP_BEQ;
    PCWriteBne = state == BRANCH && op_q == OP_BNE;
    IRWrite    = state == FETCH && MemReady;
    MemRead    = state == FETCH || state == MEM_RD;
    MemWrite   = state == MEM_WR;
    IorD       = state == MEM_RD || state == MEM_WR;
    RegWrite   = state == WB_R || state == WB_I || state == MEM_WB;
    RegDst     = state == WB_R;
    MemToReg   = state == MEM_WB;
    ALUSrcA    = state == EXEC_R || state == EXEC_I || state == MEM_ADDR || state == BRANCH;
    ALUSrcB    = state == FETCH ? 2'd1 : state == DECODE ? 2'd3 :
                 (state == EXEC_I || state == MEM_ADDR) ? 2'd2 : 2'd0;
    ALUOp      = state == EXEC_R ? 2'd2 : state == BRANCH ? 2'd1 : 2'd0;
    PCSource   = state == BRANCH ? 2'd1 : state == JUMP ? 2'd2 : 2'd0;
    State      = state;
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed-vector bench for the multicycle control FSM
module tb_mc_control_fsm;
  logic       CLK = 0;
  logic       Reset = 1;
  logic [3:0] Opcode = 0;
  logic       MemReady = 1;
  logic       PCWrite, PCWriteBeq, PCWriteBne, IRWrite, MemRead, MemWrite, IorD;
  logic       RegWrite, RegDst, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic [16:0] outs;
  int checks = 0;
  int errors = 0;

  mc_control_fsm #(.OP_W(4), .ST_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteBeq(PCWriteBeq), .PCWriteBne(PCWriteBne), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State)
  );

  assign outs = {PCWrite, PCWriteBeq, PCWriteBne, IRWrite, MemRead, MemWrite, IorD,
                 RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  always #5 CLK = ~CLK;

  // Pulse reset; on return the FSM is in RST_IDLE and reaches FETCH at the next edge
  task automatic restart();
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
  endtask

  task automatic test_reset();
    Reset = 1; MemReady = 1; Opcode = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if (State !== 4'd0 || outs !== 17'd0) begin
      errors++; $display("FAIL reset_hold: State=%0d outs=%h, want State=0 outs=0", State, outs);
    end
    Reset = 0;
    repeat (3) @(negedge CLK);
    checks++;
    if (State !== 4'd3) begin
      errors++; $display("FAIL reset_pre: State=%0d, want 3", State);
    end
    @(posedge CLK); #2; Reset = 1; #1;
    checks++;
    if (State !== 4'd0 || outs !== 17'd0) begin
      errors++; $display("FAIL reset_async: State=%0d outs=%h, want State=0 outs=0", State, outs);
    end
    @(negedge CLK); Reset = 0;
    @(negedge CLK);
    checks++;
    if (State !== 4'd1) begin
      errors++; $display("FAIL reset_edge1: State=%0d, want 1", State);
    end
    @(negedge CLK);
    checks++;
    if (State !== 4'd2) begin
      errors++; $display("FAIL reset_edge2: State=%0d, want 2", State);
    end
  endtask

  task automatic test_rtype();
    int exp_st [5];
    int exp_rw [5];
    int exp_pcw [5];
    exp_st = '{1, 2, 3, 4, 1};
    exp_rw = '{0, 0, 0, 1, 0};
    exp_pcw = '{1, 0, 0, 0, 1};
    Opcode = 0; MemReady = 1;
    restart();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      checks++;
      if (State !== exp_st[i][3:0] || RegWrite !== exp_rw[i][0] || RegDst !== exp_rw[i][0] ||
          PCWrite !== exp_pcw[i][0]) begin
        errors++;
        $display("FAIL rtype[%0d]: State=%0d RegWrite=%b RegDst=%b PCWrite=%b, want State=%0d RegWrite=%0d RegDst=%0d PCWrite=%0d",
                 i, State, RegWrite, RegDst, PCWrite, exp_st[i], exp_rw[i], exp_rw[i], exp_pcw[i]);
      end
    end
    @(negedge CLK);
    checks++;
    if (State !== 4'd2 || ALUSrcB !== 2'd3 || ALUSrcA !== 1'b0 || ALUOp !== 2'd0) begin
      errors++; $display("FAIL decode_ctl: State=%0d ALUSrcA=%b ALUSrcB=%0d ALUOp=%0d, want 2 0 3 0", State, ALUSrcA, ALUSrcB, ALUOp);
    end
  endtask

  task automatic test_lw_stall();
    int exp_st [9];
    int mr [9];
    exp_st = '{1, 2, 7, 8, 8, 8, 8, 9, 1};
    mr     = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    Opcode = 2; MemReady = 1;
    restart();
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      MemReady = mr[i][0];
      if (i == 2) Opcode = 3;
      #1;
      checks++;
      if (State !== exp_st[i][3:0]) begin
        errors++; $display("FAIL lw_state[%0d]: State=%0d, want %0d", i, State, exp_st[i]);
      end
      if (exp_st[i] == 8) begin
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b1 || MemWrite !== 1'b0) begin
          errors++; $display("FAIL lw_memrd[%0d]: MemRead=%b IorD=%b MemWrite=%b, want 1 1 0", i, MemRead, IorD, MemWrite);
        end
      end
      if (exp_st[i] == 9) begin
        checks++;
        if (MemToReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
          errors++; $display("FAIL lw_memwb: MemToReg=%b RegWrite=%b RegDst=%b, want 1 1 0", MemToReg, RegWrite, RegDst);
        end
      end
    end
    MemReady = 1;
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] op;
      op = (k == 0) ? 4'd4 : 4'd5;
      Opcode = op; MemReady = 1;
      restart();
      repeat (3) @(negedge CLK);
      Opcode = (k == 0) ? 4'd5 : 4'd4;
      #1;
      checks++;
      if (State !== 4'd11 || PCWriteBeq !== (k == 0) || PCWriteBne !== (k == 1) ||
          PCSource !== 2'd1 || PCWrite !== 1'b0 || ALUOp !== 2'd1) begin
        errors++;
        $display("FAIL branch_op%0d: State=%0d Beq=%b Bne=%b PCSource=%0d PCWrite=%b ALUOp=%0d, want 11 %0d %0d 1 0 1",
                 op, State, PCWriteBeq, PCWriteBne, PCSource, PCWrite, ALUOp, k == 0, k == 1);
      end
      @(negedge CLK);
      checks++;
      if (State !== 4'd1) begin
        errors++; $display("FAIL branch_ret%0d: State=%0d, want 1", op, State);
      end
    end
  endtask

  task automatic test_fetch_stall();
    int mr [5];
    int exp_st [5];
    mr     = '{0, 0, 1, 1, 1};
    exp_st = '{1, 1, 1, 2, 1};
    Opcode = 7; MemReady = 0;
    restart();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      MemReady = mr[i][0];
      #1;
      checks++;
      if (State !== exp_st[i][3:0]) begin
        errors++; $display("FAIL stall_state[%0d]: State=%0d, want %0d", i, State, exp_st[i]);
      end
      if (i < 3) begin
        checks++;
        if (IRWrite !== mr[i][0] || PCWrite !== mr[i][0] || MemRead !== 1'b1 || ALUSrcB !== 2'd1) begin
          errors++;
          $display("FAIL stall_fetch[%0d]: IRWrite=%b PCWrite=%b MemRead=%b ALUSrcB=%0d, want %0d %0d 1 1",
                   i, IRWrite, PCWrite, MemRead, ALUSrcB, mr[i], mr[i]);
        end
      end
    end
  endtask

  task automatic test_cycles();
    logic [3:0] ops [5];
    int exp_n [5];
    ops   = '{4'd1, 4'd3, 4'd6, 4'd9, 4'd0};
    exp_n = '{4, 4, 3, 2, 4};
    MemReady = 1;
    for (int k = 0; k < 5; k++) begin
      int n;
      Opcode = ops[k];
      restart();
      @(negedge CLK);
      n = 1;
      @(negedge CLK);
      while (State !== 4'd1 && n < 20) begin
        checks++;
        if ((PCWrite + PCWriteBeq + PCWriteBne) > 1 || (MemRead && MemWrite)) begin
          errors++; $display("FAIL invariant_op%0d: PCW=%b Beq=%b Bne=%b MemRead=%b MemWrite=%b", ops[k], PCWrite, PCWriteBeq, PCWriteBne, MemRead, MemWrite);
        end
        if (State == 4'd12) begin
          checks++;
          if (PCWrite !== 1'b1 || PCSource !== 2'd2) begin
            errors++; $display("FAIL jump_ctl: PCWrite=%b PCSource=%0d, want 1 2", PCWrite, PCSource);
          end
        end
        if (State == 4'd10) begin
          checks++;
          if (MemWrite !== 1'b1 || IorD !== 1'b1 || MemRead !== 1'b0) begin
            errors++; $display("FAIL sw_ctl: MemWrite=%b IorD=%b MemRead=%b, want 1 1 0", MemWrite, IorD, MemRead);
          end
        end
        n++;
        @(negedge CLK);
      end
      checks++;
      if (n != exp_n[k]) begin
        errors++; $display("FAIL cycles_op%0d: got %0d cycles, want %0d", ops[k], n, exp_n[k]);
      end
    end
  endtask

  task automatic test_halt();
    Opcode = 4'hF; MemReady = 1;
    restart();
    repeat (3) @(negedge CLK);
    Opcode = 0;
    checks++;
    if (State !== 4'd13) begin
      errors++; $display("FAIL halt_enter: State=%0d, want 13", State);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (State !== 4'd13 || outs !== 17'd0) begin
        errors++; $display("FAIL halt_hold[%0d]: State=%0d outs=%h, want 13 0", i, State, outs);
      end
    end
    #2; Reset = 1; #1;
    checks++;
    if (State !== 4'd0) begin
      errors++; $display("FAIL halt_reset: State=%0d, want 0", State);
    end
    @(negedge CLK); Reset = 0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_fetch_stall();
    test_cycles();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control state machine for the 16-bit datapath.
- Sits directly upstream of the PC register and drives its PCWrite, PCWriteBeq and PCWriteBne enables.
- Also drives the IR, memory, register-file and ALU mux controls.
- Sequences each instruction from the opcode field through fetch, decode, execute, memory and writeback, stalling on a memory-ready handshake.

Parameters:
- OP_W, 4, opcode width (Instr[15:12]).
- ST_W, 4, state encoding width.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  4  IR[15:12], valid from DECODE onward.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteBeq  out  1  PC load if Is_Zero.
- PCWriteBne  out  1  PC load if !Is_Zero.
- IRWrite  out  1  instruction register load.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IorD  out  1  0=PC address, 1=ALUOut address.
- RegWrite  out  1  register file write.
- RegDst  out  1  0=rt, 1=rd.
- MemToReg  out  1  0=ALUOut, 1=MDR.
- ALUSrcA  out  1  0=PC, 1=regA.
- ALUSrcB  out  2  0=regB, 1=const 2, 2=sign-ext imm, 3=sign-ext imm<<1.
- ALUOp  out  2  0=add, 1=sub, 2=funct-decoded.
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- State  out  4  current state, for debug and verification.

Behaviour:
- Opcodes: 0 R-type; 1 addi; 2 lw; 3 sw; 4 beq; 5 bne; 6 j; F halt. 7–E are NOPs.
- States (encoding): RST_IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, MEM_WB=9, MEM_WR=10, BRANCH=11, JUMP=12, HALT=13. Other encodings go to RST_IDLE on the next edge.
- Reset asserted, at any time including mid-instruction: State=RST_IDLE immediately (asynchronous) and every output is 0.
- RST_IDLE: all outputs 0; next state FETCH after Reset deasserts.
- FETCH:
  - Always drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=3, ALUOp=0 to precompute the branch target.
  - Next state: 0→EXEC_R, 1→EXEC_I, 2/3→MEM_ADDR, 4/5→BRANCH, 6→JUMP, F→HALT, 7–E→FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2; next WB_R.
- WB_R: RegWrite=1, RegDst=1, MemToReg=0; next FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=0; next WB_I.
- WB_I: RegWrite=1, RegDst=0, MemToReg=0; next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0; next MEM_RD if the latched opcode is 2, else MEM_WR.
- MEM_RD: MemRead=1, IorD=1; holds until MemReady=1, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemToReg=1; next FETCH.
- MEM_WR: MemWrite=1, IorD=1; holds until MemReady=1, then FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1.
  - PCWriteBeq=1 if opcode 4; PCWriteBne=1 if opcode 5. Never both.
  - Next FETCH.
- JUMP: PCWrite=1, PCSource=2; next FETCH.
- HALT: all outputs 0; stays in HALT until Reset.
- Opcode is sampled at the DECODE→ edge and held internally through the instruction. Opcode changes after DECODE are ignored.
- Outputs are combinational from state, plus MemReady in FETCH only.
- Invariants:
  - At most one of PCWrite, PCWriteBeq, PCWriteBne is high in any cycle.
  - MemRead and MemWrite are never both high.
- Cycle counts with MemReady held high: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3, NOP 2.

Test Plan:
- Assert Reset mid-cycle, MemReady=1 → State=0 and all outputs 0 before the next edge. After deassert: State=1 on the first edge, 2 on the second.
- Opcode=0, MemReady=1 → State sequence 1,2,3,4,1. RegWrite=1 and RegDst=1 only in state 4. PCWrite=1 only in state 1.
- Opcode=2, MemReady low for 3 cycles in MEM_RD → State sequence 1,2,7,8,8,8,8,9,1. MemRead=IorD=1 throughout state 8. MemToReg=1 in state 9.
- Opcode=4 → PCWriteBeq=1, PCWriteBne=0, PCSource=1 in state 11. Opcode=5 → PCWriteBne=1, PCWriteBeq=0 in state 11.
- MemReady=0 for 2 cycles in FETCH → IRWrite=PCWrite=0 while stalled; both go to 1 in the cycle MemReady=1.
- Opcode=F → State reaches 13 and holds for 10 cycles with all outputs 0. Reset returns State to 0.
